// File: rtl/ccd_frame_capture.sv
// ccd_frame_capture
//   Frame capture stage behind the D5M input register stage. It takes the
//   registered 12-bit pixel stream and its line/frame valid strobes. Capture
//   is gated to whole frames under start/stop control. It emits qualified
//   pixels tagged with X/Y coordinates and per-frame statistics.
//
// Ports
//   im_D5M_PIXLCLK  pixel clock, all logic on the rising edge
//   im_RST          synchronous active-high reset
//   im_rCCD_DATA    registered pixel data
//   im_rCCD_LVAL    registered line valid
//   im_rCCD_FVAL    registered frame valid
//   im_START        pulse: request continuous capture
//   im_END          pulse: stop at the next frame boundary (wins over START)
//   om_DATA/om_X/om_Y  captured pixel and its column/row, hold when idle
//   om_DVAL         pixel valid strobe
//   om_SOF          first pixel of a captured frame
//   om_FRAME_DONE   one-cycle pulse after a captured frame ends
//   om_FRAME_CNT    completed captured frames (wraps)
//   om_LINES        line count of the last completed frame
//   om_LINE_LEN     pixel count of the last completed line
//   om_BUSY         capture engine not idle
module ccd_frame_capture #(
  parameter int DATA_W = 12,
  parameter int X_W    = 16,
  parameter int Y_W    = 16
) (
  input  logic              im_D5M_PIXLCLK,
  input  logic              im_RST,
  input  logic [DATA_W-1:0] im_rCCD_DATA,
  input  logic              im_rCCD_LVAL,
  input  logic              im_rCCD_FVAL,
  input  logic              im_START,
  input  logic              im_END,
  output logic [DATA_W-1:0] om_DATA,
  output logic              om_DVAL,
  output logic [X_W-1:0]    om_X,
  output logic [Y_W-1:0]    om_Y,
  output logic              om_SOF,
  output logic              om_FRAME_DONE,
  output logic [31:0]       om_FRAME_CNT,
  output logic [Y_W-1:0]    om_LINES,
  output logic [X_W-1:0]    om_LINE_LEN,
  output logic              om_BUSY
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;

  logic [1:0]     state;
  logic [1:0]     state_nx;
  logic           run;
  logic           run_nx;
  logic           fval_d;
  logic           lval_d;
  logic [X_W-1:0] x_cnt;
  logic [Y_W-1:0] y_cnt;

  logic           fval_rise;
  logic           fval_fall;
  logic           lval_fall;
  logic           start_frame;
  logic           frame_active;
  logic           pix;
  logic           line_close;
  logic           frame_close;
  logic [X_W-1:0] x_base;
  logic [Y_W-1:0] y_base;

  always_comb begin
    fval_rise    = im_rCCD_FVAL & ~fval_d;
    fval_fall    = ~im_rCCD_FVAL & fval_d;
    lval_fall    = ~im_rCCD_LVAL & lval_d;

    // END has priority over START when both arrive together.
    run_nx       = im_END ? 1'b0 : (im_START ? 1'b1 : run);

    start_frame  = (state == ST_ARMED) & fval_rise;
    frame_active = start_frame | ((state == ST_CAPTURE) & im_rCCD_FVAL);
    pix          = frame_active & im_rCCD_LVAL;
    line_close   = (state == ST_CAPTURE) & lval_fall;
    frame_close  = (state == ST_CAPTURE) & fval_fall;

    // The frame-start cycle addresses pixel (0,0) regardless of stale counts.
    x_base       = start_frame ? '0 : x_cnt;
    y_base       = start_frame ? '0 : y_cnt;

    // run is always clear while IDLE, so arming follows run_nx alone.
    state_nx = state;
    case (state)
      ST_IDLE:    if (run_nx) state_nx = ST_ARMED;
      ST_ARMED: begin
        if (fval_rise)    state_nx = ST_CAPTURE;
        else if (!run_nx) state_nx = ST_IDLE;
      end
      ST_CAPTURE: if (fval_fall) state_nx = run_nx ? ST_ARMED : ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge im_D5M_PIXLCLK) begin
    if (im_RST) begin
      state         <= ST_IDLE;
      run           <= 1'b0;
      fval_d        <= 1'b0;
      lval_d        <= 1'b0;
      x_cnt         <= '0;
      y_cnt         <= '0;
      om_DATA       <= '0;
      om_DVAL       <= 1'b0;
      om_X          <= '0;
      om_Y          <= '0;
      om_SOF        <= 1'b0;
      om_FRAME_DONE <= 1'b0;
      om_FRAME_CNT  <= '0;
      om_LINES      <= '0;
      om_LINE_LEN   <= '0;
      om_BUSY       <= 1'b0;
    end else begin
      fval_d        <= im_rCCD_FVAL;
      lval_d        <= im_rCCD_LVAL;
      run           <= run_nx;
      state         <= state_nx;
      om_BUSY       <= (state_nx != ST_IDLE);
      om_DVAL       <= pix;
      om_SOF        <= pix & (x_base == '0) & (y_base == '0);
      om_FRAME_DONE <= frame_close;

      if (start_frame) begin
        x_cnt <= '0;
        y_cnt <= '0;
      end

      // pix needs LVAL high and line_close needs LVAL low: never both.
      if (pix) begin
        om_DATA <= im_rCCD_DATA;
        om_X    <= x_base;
        om_Y    <= y_base;
        x_cnt   <= x_base + X_W'(1);
      end

      if (line_close) begin
        om_LINE_LEN <= x_cnt;
        x_cnt       <= '0;
        y_cnt       <= y_cnt + Y_W'(1);
      end

      // Frame close overrides the line-close counter update; a line that
      // ends on the same cycle as the frame is still counted.
      if (frame_close) begin
        om_FRAME_CNT <= om_FRAME_CNT + 32'd1;
        om_LINES     <= y_cnt + Y_W'(lval_fall);
        x_cnt        <= '0;
        y_cnt        <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ccd_frame_capture.sv
// Testbench for ccd_frame_capture: directed scenarios plus randomized frames
// with random start/stop pulses and resets, compared every cycle against a
// behavioural frame-capture model.
module tb_ccd_frame_capture;

  localparam int DATA_W = 12;
  localparam int X_W    = 16;
  localparam int Y_W    = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] din = '0;
  logic              lval = 1'b0;
  logic              fval = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;

  logic [DATA_W-1:0] o_data;
  logic              o_dval;
  logic [X_W-1:0]    o_x;
  logic [Y_W-1:0]    o_y;
  logic              o_sof;
  logic              o_done;
  logic [31:0]       o_cnt;
  logic [Y_W-1:0]    o_lines;
  logic [X_W-1:0]    o_len;
  logic              o_busy;

  always #5 clk = ~clk;

  ccd_frame_capture #(.DATA_W(DATA_W), .X_W(X_W), .Y_W(Y_W)) dut (
    .im_D5M_PIXLCLK(clk),
    .im_RST        (rst),
    .im_rCCD_DATA  (din),
    .im_rCCD_LVAL  (lval),
    .im_rCCD_FVAL  (fval),
    .im_START      (start),
    .im_END        (stop),
    .om_DATA       (o_data),
    .om_DVAL       (o_dval),
    .om_X          (o_x),
    .om_Y          (o_y),
    .om_SOF        (o_sof),
    .om_FRAME_DONE (o_done),
    .om_FRAME_CNT  (o_cnt),
    .om_LINES      (o_lines),
    .om_LINE_LEN   (o_len),
    .om_BUSY       (o_busy)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  int dval_seen = 0;
  int sof_seen = 0;
  int done_seen = 0;

  // Behavioural model: "want" is the user's capture request, "waiting" means
  // looking for the start of a fresh frame, "capturing" means inside one.
  bit          m_want, m_wait, m_cap, m_pf, m_pl;
  logic [15:0] m_col, m_row;
  logic [DATA_W-1:0] e_data;
  logic [15:0] e_x, e_y, e_lines, e_len;
  logic [31:0] e_cnt;
  bit          e_dval, e_sof, e_done, e_busy;

  task automatic emit(input logic [DATA_W-1:0] d);
    e_dval = 1'b1;
    e_data = d;
    e_x    = m_col;
    e_y    = m_row;
    e_sof  = (m_col == 16'd0) && (m_row == 16'd0);
    m_col  = m_col + 16'd1;
  endtask

  task automatic model_step(input bit r, input logic [DATA_W-1:0] d,
                            input bit l, input bit f, input bit s, input bit e);
    bit rise, fall, lfall, want_nx;
    if (r) begin
      m_want = 0; m_wait = 0; m_cap = 0; m_pf = 0; m_pl = 0;
      m_col = 0; m_row = 0; e_data = 0; e_x = 0; e_y = 0; e_lines = 0;
      e_len = 0; e_cnt = 0; e_dval = 0; e_sof = 0; e_done = 0; e_busy = 0;
      return;
    end
    rise    = f && !m_pf;
    fall    = !f && m_pf;
    lfall   = !l && m_pl;
    want_nx = e ? 1'b0 : (s ? 1'b1 : m_want);
    e_dval = 0; e_sof = 0; e_done = 0;
    if (m_cap) begin
      if (fall) begin
        e_done  = 1;
        e_cnt   = e_cnt + 32'd1;
        e_lines = m_row + (lfall ? 16'd1 : 16'd0);
        if (lfall) e_len = m_col;
        m_col = 0; m_row = 0;
        m_cap  = 0;
        m_wait = want_nx;
      end else begin
        if (lfall) begin
          e_len = m_col;
          m_col = 0;
          m_row = m_row + 16'd1;
        end
        if (l) emit(d);
      end
    end else if (m_wait && rise) begin
      m_wait = 0;
      m_cap  = 1;
      m_col  = 0;
      m_row  = 0;
      if (l) emit(d);
    end else begin
      m_wait = want_nx;
    end
    m_want = want_nx;
    m_pf   = f;
    m_pl   = l;
    e_busy = m_wait || m_cap;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      checks++;
      if ({o_data, o_dval, o_x, o_y, o_sof, o_done, o_cnt, o_lines, o_len, o_busy} !==
          {e_data, e_dval, e_x, e_y, e_sof, e_done, e_cnt, e_lines, e_len, e_busy}) begin
        failures++;
        $display("FAIL outputs t=%0t got dval=%b sof=%b done=%b busy=%b data=%h x=%0d y=%0d cnt=%0d lines=%0d len=%0d | exp dval=%b sof=%b done=%b busy=%b data=%h x=%0d y=%0d cnt=%0d lines=%0d len=%0d",
                 $time, o_dval, o_sof, o_done, o_busy, o_data, o_x, o_y, o_cnt, o_lines, o_len,
                 e_dval, e_sof, e_done, e_busy, e_data, e_x, e_y, e_cnt, e_lines, e_len);
      end
      if (o_dval === 1'b1) dval_seen++;
      if (o_sof === 1'b1)  sof_seen++;
      if (o_done === 1'b1) done_seen++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit l, input bit f, input bit s, input bit e);
    din   = DATA_W'($urandom);
    rst   = r;
    lval  = l;
    fval  = f;
    start = s;
    stop  = e;
    model_step(r, din, l, f, s, e);
    @(posedge clk);
    #3;
  endtask

  function automatic bit pr(input bit rnd, input int n);
    return rnd && ($urandom_range(0, n - 1) == 0);
  endfunction

  // One frame: lead cycle with FVAL high, nl lines of np pixels separated by
  // gap idle cycles, then FVAL falls (together with LVAL when fold is set),
  // followed by two blank cycles.
  task automatic frame(input int nl, input int np, input int gap, input bit fold,
                       input int st_line, input int end_line, input bit rnd,
                       input bit lead_l);
    step(0, lead_l, 1, pr(rnd, 12), pr(rnd, 25));
    for (int ln = 0; ln < nl; ln++) begin
      for (int p = 0; p < np; p++)
        step(0, 1, 1, (ln == st_line && p == 0) || pr(rnd, 12),
             (ln == end_line && p == 0) || pr(rnd, 25));
      if (ln == nl - 1) begin
        if (!fold)
          for (int g = 0; g < ((gap < 1) ? 1 : gap); g++)
            step(0, 0, 1, pr(rnd, 12), pr(rnd, 25));
        step(0, 0, 0, pr(rnd, 12), pr(rnd, 25));
      end else begin
        for (int g = 0; g < gap; g++) step(0, 0, 1, pr(rnd, 12), pr(rnd, 25));
      end
    end
    for (int i = 0; i < 2; i++) step(0, 0, 0, pr(rnd, 12), pr(rnd, 25));
  endtask

  int d0, s0, f0;

  initial begin
    chk_en = 1'b1;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("reset_busy", 32'(o_busy), 32'd0);
    chk("reset_cnt", o_cnt, 32'd0);

    // Basic 3x4 frame, two idle cycles between lines.
    step(0, 0, 0, 1, 0);
    d0 = dval_seen; s0 = sof_seen;
    frame(3, 4, 2, 0, -1, -1, 0, 0);
    chk("t1_dval_count", 32'(dval_seen - d0), 32'd12);
    chk("t1_sof_count", 32'(sof_seen - s0), 32'd1);
    chk("t1_frame_cnt", o_cnt, 32'd1);
    chk("t1_lines", 32'(o_lines), 32'd3);
    chk("t1_line_len", 32'(o_len), 32'd4);
    chk("t1_model_cnt", e_cnt, 32'd1);
    chk("t1_model_lines", 32'(e_lines), 32'd3);
    chk("t1_busy_armed", 32'(o_busy), 32'd1);

    // Stop, then START mid-frame: that frame is skipped, the next is whole.
    step(0, 0, 0, 0, 1);
    chk("t2_idle", 32'(o_busy), 32'd0);
    d0 = dval_seen;
    frame(3, 4, 1, 0, 1, -1, 0, 0);
    chk("t2_mid_start_dval", 32'(dval_seen - d0), 32'd0);
    chk("t2_armed", 32'(o_busy), 32'd1);
    d0 = dval_seen; s0 = sof_seen;
    frame(2, 3, 1, 0, -1, -1, 0, 0);
    chk("t2_next_dval", 32'(dval_seen - d0), 32'd6);
    chk("t2_next_sof", 32'(sof_seen - s0), 32'd1);
    chk("t2_frame_cnt", o_cnt, 32'd2);

    // END on line 1: frame completes, then engine idles.
    d0 = dval_seen;
    frame(3, 4, 1, 0, -1, 1, 0, 0);
    chk("t3_dval", 32'(dval_seen - d0), 32'd12);
    chk("t3_frame_cnt", o_cnt, 32'd3);
    chk("t3_busy", 32'(o_busy), 32'd0);
    d0 = dval_seen;
    frame(2, 2, 1, 0, -1, -1, 0, 0);
    chk("t3_after_dval", 32'(dval_seen - d0), 32'd0);

    // START and END together while idle.
    step(0, 0, 0, 1, 1);
    chk("t4_busy", 32'(o_busy), 32'd0);
    d0 = dval_seen;
    frame(2, 2, 1, 0, -1, -1, 0, 0);
    chk("t4_dval", 32'(dval_seen - d0), 32'd0);

    // LVAL and FVAL fall together on a 2x5 frame.
    step(0, 0, 0, 1, 0);
    frame(2, 5, 1, 1, -1, -1, 0, 0);
    chk("t5_lines", 32'(o_lines), 32'd2);
    chk("t5_line_len", 32'(o_len), 32'd5);
    chk("t5_frame_cnt", o_cnt, 32'd4);

    // Reset in the middle of line 1.
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    chk("t6_rst_data", 32'(o_data), 32'd0);
    chk("t6_rst_x", 32'(o_x), 32'd0);
    chk("t6_rst_y", 32'(o_y), 32'd0);
    chk("t6_rst_dval", 32'(o_dval), 32'd0);
    chk("t6_rst_cnt", o_cnt, 32'd0);
    chk("t6_rst_lines", 32'(o_lines), 32'd0);
    chk("t6_rst_len", 32'(o_len), 32'd0);
    chk("t6_rst_busy", 32'(o_busy), 32'd0);
    d0 = dval_seen; f0 = done_seen;
    for (int i = 0; i < 2; i++) step(0, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("t6_no_done", 32'(done_seen - f0), 32'd0);
    chk("t6_no_dval", 32'(dval_seen - d0), 32'd0);
    step(0, 0, 0, 1, 0);
    s0 = sof_seen;
    frame(3, 4, 2, 0, -1, -1, 0, 0);
    chk("t6_frame_cnt", o_cnt, 32'd1);
    chk("t6_sof", 32'(sof_seen - s0), 32'd1);
    chk("t6_dval", 32'(dval_seen - d0), 32'd12);

    // Randomized frames with random START/END pulses and occasional reset.
    step(0, 0, 0, 1, 0);
    for (int it = 0; it < 250; it++) begin
      if ($urandom_range(0, 39) == 0) step(1, $urandom_range(0, 1), $urandom_range(0, 1), 0, 0);
      frame($urandom_range(1, 4), $urandom_range(1, 6), $urandom_range(0, 3),
            bit'($urandom_range(0, 1)), -1, -1, 1, bit'($urandom_range(0, 1)));
      for (int i = 0; i < $urandom_range(0, 2); i++)
        step(0, $urandom_range(0, 1), 0, pr(1, 8), pr(1, 25));
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
